vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk25MHz, input, 1, pixel clock.
REQ-010 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-011 SHALL have port en, input, 1, count enable; low freezes all state.
REQ-012 SHALL have port pos_x, output, 9, visible column divided by 2 (0..319).
REQ-013 SHALL have port pos_y, output, 9, visible line divided by 2 (0..239).
REQ-014 SHALL have port active, output, 1, current pixel is inside the visible area.
REQ-015 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-016 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-017 SHALL have port line_start, output, 1, one-cycle pulse at h=0 of every line.
REQ-018 SHALL have port frame_start, output, 1, one-cycle pulse at h=0, v=0.
REQ-019 SHALL have port frame_cnt, output, 8, frames begun since reset, modulo 256.

Function
REQ-020 SHALL keep horizontal index h over 0..H_TOTAL-1 (H_TOTAL = sum of H_*, 800) and vertical index v over 0..V_TOTAL-1 (525).
REQ-021 SHALL drive every output from a flop; all outputs SHALL describe the same pixel (h,v) in a given cycle.
REQ-022 SHALL advance (h,v) by one pixel per rising edge while en=1: h increments; at h=H_TOTAL-1, h wraps to 0 and v increments; at h=H_TOTAL-1 and v=V_TOTAL-1, both wrap to 0.
REQ-023 SHALL hold all outputs, including the line_start and frame_start levels, unchanged on any edge where en=0.
REQ-024 SHALL assert active iff h<H_ACTIVE and v<V_ACTIVE.
REQ-025 SHALL set pos_x=h>>1 and pos_y=v>>1 when active=1, and pos_x=pos_y=0 when active=0.
REQ-026 SHALL drive hsync=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751), else 1.
REQ-027 SHALL drive vsync=0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), else 1, on every pixel of those lines.
REQ-028 SHALL assert line_start iff h=0, and frame_start iff h=0 and v=0.
REQ-029 SHALL increment frame_cnt on the same edge that frame_start rises, wrapping 255->0.
REQ-030 SHALL present pixel (0,0) (active=1, frame_start=1, frame_cnt=1) on the first enabled edge after rst_n deasserts.

Reset
REQ-031 SHALL, while rst_n=0, force pos_x=0, pos_y=0, active=0, hsync=1, vsync=1, line_start=0, frame_start=0, frame_cnt=0, independent of clk25MHz.
REQ-032 SHALL, on reset asserted mid-frame, abandon the frame and restart per REQ-030 after release.

Structure
REQ-033 SHALL place the default timing constants and derived H_TOTAL/V_TOTAL in shared package vga_timing_pkg.
REQ-034 SHALL instantiate sub-module vga_axis_counter twice (horizontal, vertical): wrapping counter with enable, terminal-count output, and registered sync/active decode.
REQ-035 SHALL be sized at roughly 150-250 lines of RTL including the sub-module.

Verification
REQ-036 SHALL test reset release with en=1: the first edge gives active=1, pos=(0,0), frame_start=1, frame_cnt=1; the next edge gives pos_x=0 (h=1) and line_start=0.
REQ-037 SHALL test one full line: active is high for exactly 640 cycles, hsync is low for 96 cycles starting 656 cycles after line_start, and line_start repeats every 800 cycles.
REQ-038 SHALL test one full frame: frame_start recurs every 420000 cycles, vsync is low for exactly 1600 cycles, and pos_y reaches 239 and never exceeds it.
REQ-039 SHALL test en held low for 10 cycles at h=639: all outputs are frozen, and h=640 then gives active=0 and pos=(0,0).
REQ-040 SHALL test reset asserted at v=300 between clock edges: outputs go to reset values immediately, and restart follows REQ-030.
REQ-041 SHALL test 256 frames of run time: frame_cnt wraps to 0 on the 256th frame_start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants shared by the VGA timing block.
package vga_timing_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping axis counter with terminal count and registered sync decode.
// Reset parks the count at TOTAL-1 so the first step lands on 0.
module vga_axis_counter #(
    parameter int TOTAL  = 800,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int W      = $clog2(TOTAL)
) (
    input  logic         clk25MHz,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] nxt,
    output logic         tc,
    output logic         nact,
    output logic         sync_n
);
    logic [W-1:0] cnt;
    assign tc   = cnt == W'(TOTAL - 1);
    assign nxt  = !step ? cnt : tc ? '0 : cnt + 1'b1;
    assign nact = nxt < W'(ACTIVE);
    always_ff @(posedge clk25MHz or negedge rst_n)
        if (!rst_n) begin
            cnt    <= W'(TOTAL - 1);
            sync_n <= 1'b1;
        end else begin
            cnt    <= nxt;
            sync_n <= !(nxt >= W'(ACTIVE + FP) && nxt < W'(ACTIVE + FP + SYNC));
        end
endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster generator; every output is a flop describing the same pixel (h,v).
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk25MHz,
    input  logic       rst_n,
    input  logic       en,
    output logic [8:0] pos_x,
    output logic [8:0] pos_y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic h_tc, v_tc, h_nact, v_nact, nact;
    vga_axis_counter #(.TOTAL(HT), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .W(HW)) u_h (
        .clk25MHz(clk25MHz), .rst_n(rst_n), .step(en),
        .nxt(h_nxt), .tc(h_tc), .nact(h_nact), .sync_n(hsync)
    );
    vga_axis_counter #(.TOTAL(VT), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .W(VW)) u_v (
        .clk25MHz(clk25MHz), .rst_n(rst_n), .step(en && h_tc),
        .nxt(v_nxt), .tc(v_tc), .nact(v_nact), .sync_n(vsync)
    );
    assign nact = h_nact && v_nact;
    // Decode the pixel about to be entered so outputs line up with the counters.
    always_ff @(posedge clk25MHz or negedge rst_n)
        if (!rst_n) begin
            pos_x       <= '0;
            pos_y       <= '0;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (en) begin
            pos_x       <= nact ? 9'(h_nxt >> 1) : '0;
            pos_y       <= nact ? 9'(v_nxt >> 1) : '0;
            active      <= nact;
            line_start  <= h_tc;
            frame_start <= h_tc && v_tc;
            frame_cnt   <= frame_cnt + 8'(h_tc && v_tc);
        end
endmodule
